bcd_serial_adder: RTL and testbench

- Multi-digit packed-BCD adder, processed serially one digit per clock, LSD first.
- Sits downstream of and wraps the single-digit BCD add stage: it sequences digit pairs and the inter-digit carry through that stage, then assembles the full result.
- Validates every digit as it is processed and aborts with an error flag and digit index on the first non-BCD nibble.

---
 rtl/bcd_serial_adder_if.sv | 29 ++
 rtl/bcd_serial_adder.sv | 121 ++++++++++++
 tb/tb_bcd_serial_adder.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/bcd_serial_adder_if.sv
// Operand/result bundle for the serial packed-BCD adder.
// Adds no latency: the interface holds nets only.
// Has no backpressure: start is only sampled while the adder is idle.
interface bcd_serial_adder_if #(
  parameter int DIGITS = 4,
  parameter int IDXW   = 2
);
  logic                  start;
  logic [4*DIGITS-1:0]   a;
  logic [4*DIGITS-1:0]   b;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS+3:0]   result;
  logic                  err;
  logic [IDXW-1:0]       err_idx;
  logic                  err_op;

  // Requester side: drives operands and start, observes status and result.
  modport master (
    output start, a, b,
    input  busy, done, result, err, err_idx, err_op
  );

  // Adder side.
  modport slave (
    input  start, a, b,
    output busy, done, result, err, err_idx, err_op
  );
endinterface

// File: rtl/bcd_serial_adder.sv
// Multi-digit packed-BCD adder that adds one digit per clock, least significant digit first.
// Latency: done is high DIGITS cycles after the start edge, or k+1 cycles after it for an error at digit k.
// Backpressure: none. Start is accepted only in IDLE; while busy it is ignored, not queued.
module bcd_serial_adder #(
  parameter int DIGITS = 4,
  parameter int IDXW   = 2
) (
  input  logic                clk,
  input  logic                rst,
  bcd_serial_adder_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                state_q, state_d;
  logic [4*DIGITS-1:0]   a_q, b_q;
  logic [IDXW-1:0]       idx_q;
  logic                  carry_q;
  logic [4*DIGITS+3:0]   result_q;
  logic                  err_q;
  logic [IDXW-1:0]       err_idx_q;
  logic                  err_op_q;

  // Single-digit stage signals for the digit currently addressed by idx_q.
  logic [3:0]            a_d, b_d;
  logic                  a_bad, b_bad;
  logic [4:0]            sum5;
  logic [3:0]            dig;
  logic                  cout;
  logic                  last;

  // Select the current digit pair and run the single-digit BCD add with decimal correction.
  always_comb begin
    a_d = 4'd0;
    b_d = 4'd0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_q == IDXW'(i)) begin
        a_d = a_q[4*i +: 4];
        b_d = b_q[4*i +: 4];
      end
    end
    a_bad = (a_d > 4'd9);
    b_bad = (b_d > 4'd9);
    sum5  = {1'b0, a_d} + {1'b0, b_d} + {4'd0, carry_q};
    cout  = (sum5 > 5'd9);
    // The +6 correction wraps modulo 16, which yields the low decimal digit of 10..19.
    dig   = cout ? (sum5[3:0] + 4'd6) : sum5[3:0];
    last  = (idx_q == IDXW'(DIGITS - 1));
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic. DONE always lasts one cycle, so a start that coincides with done is dropped.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = RUN;
      RUN:     if (a_bad || b_bad || last) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath: latch operands at accept, then write one result digit per RUN cycle, or abort on a bad digit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q       <= '0;
      b_q       <= '0;
      idx_q     <= '0;
      carry_q   <= 1'b0;
      result_q  <= '0;
      err_q     <= 1'b0;
      err_idx_q <= '0;
      err_op_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            a_q       <= bus.a;
            b_q       <= bus.b;
            idx_q     <= '0;
            carry_q   <= 1'b0;
            result_q  <= '0;
            err_q     <= 1'b0;
            err_idx_q <= '0;
            err_op_q  <= 1'b0;
          end
        end
        RUN: begin
          if (a_bad || b_bad) begin
            // Operand A is reported when both digits are bad.
            err_q     <= 1'b1;
            err_idx_q <= idx_q;
            err_op_q  <= !a_bad;
            result_q  <= '0;
          end else begin
            for (int i = 0; i < DIGITS; i++) begin
              if (idx_q == IDXW'(i)) result_q[4*i +: 4] <= dig;
            end
            carry_q <= cout;
            if (last) result_q[4*DIGITS +: 4] <= {3'b000, cout};
            else      idx_q <= idx_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy    = (state_q != IDLE);
  assign bus.done    = (state_q == DONE);
  assign bus.result  = result_q;
  assign bus.err     = err_q;
  assign bus.err_idx = err_idx_q;
  assign bus.err_op  = err_op_q;

endmodule

// File: tb/tb_bcd_serial_adder.sv
// Self-checking bench for bcd_serial_adder with DIGITS=4.
// Uses a directed vector table, hand-written multi-cycle sequences, and random operations checked against an arithmetic model.
module tb_bcd_serial_adder;
  localparam int D = 4;
  localparam int W = 4 * D;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  bcd_serial_adder_if #(.DIGITS(D), .IDXW(2)) bus ();
  bcd_serial_adder #(.DIGITS(D), .IDXW(2)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W+3:0] res;
    logic         err;
    logic [1:0]   idx;
    logic         op;
    int           lat;
  } vec_t;

  vec_t tbl [7];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h expected=%h", name, got, exp);
    end
  endtask

  // Reference model: convert the operands to integers, add them, and convert the sum back to BCD.
  task automatic model(input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [W+3:0] r, output logic e, output logic [1:0] ei,
                       output logic eo, output int lat);
    int va = 0, vb = 0, wgt = 1, s;
    e = 1'b0; ei = 2'd0; eo = 1'b0; r = '0;
    for (int i = 0; i < D; i++) begin
      int na = int'((a >> (4*i)) & 16'hF);
      int nb = int'((b >> (4*i)) & 16'hF);
      if (!e && na > 9)      begin e = 1'b1; ei = 2'(i); eo = 1'b0; end
      else if (!e && nb > 9) begin e = 1'b1; ei = 2'(i); eo = 1'b1; end
      va += na * wgt;
      vb += nb * wgt;
      wgt *= 10;
    end
    if (e) begin
      lat = int'(ei) + 1;
    end else begin
      s = va + vb;
      for (int i = 0; i <= D; i++) begin
        r[4*i +: 4] = 4'(s % 10);
        s = s / 10;
      end
      lat = D;
    end
  endtask

  // Runs one operation: start at edge 0, observe each cycle on the falling edge, and stop one cycle past done.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic scramble,
                       output logic [W+3:0] r, output logic e, output logic [1:0] ei,
                       output logic eo, output int lat, output int busy_n);
    @(negedge clk);
    bus.a = a; bus.b = b; bus.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    if (scramble) begin
      bus.a = ~a;
      bus.b = W'($urandom);
    end
    check("start_clears_err", 32'(bus.err), 32'd0);
    check("start_clears_result", 32'(bus.result), 32'd0);
    lat = 0; busy_n = 0;
    while (!bus.done && lat < 20) begin
      if (bus.busy) busy_n++;
      @(negedge clk);
      lat++;
    end
    if (bus.busy) busy_n++;
    r = bus.result; e = bus.err; ei = bus.err_idx; eo = bus.err_op;
    @(negedge clk);
    check("idle_done_low", 32'(bus.done), 32'd0);
    check("idle_busy_low", 32'(bus.busy), 32'd0);
    check("result_hold", 32'(bus.result), 32'(r));
    check("err_hold", 32'(bus.err), 32'(e));
  endtask

  initial begin
    logic [W+3:0] r, mr;
    logic         e, eo, me, meo;
    logic [1:0]   ei, mei;
    int           lat, busy_n, mlat, dones;
    logic [W-1:0] ra, rb;

    tbl[0] = '{16'h1234, 16'h5678, 20'h06912, 1'b0, 2'd0, 1'b0, 4};
    tbl[1] = '{16'h9999, 16'h0001, 20'h10000, 1'b0, 2'd0, 1'b0, 4};
    tbl[2] = '{16'h12A4, 16'h0000, 20'h00000, 1'b1, 2'd1, 1'b0, 2};
    tbl[3] = '{16'h00F0, 16'h00B0, 20'h00000, 1'b1, 2'd1, 1'b0, 2};
    tbl[4] = '{16'h0000, 16'hC000, 20'h00000, 1'b1, 2'd3, 1'b1, 4};
    tbl[5] = '{16'h9999, 16'h9999, 20'h19998, 1'b0, 2'd0, 1'b0, 4};
    tbl[6] = '{16'h000A, 16'h000F, 20'h00000, 1'b1, 2'd0, 1'b0, 1};

    bus.start = 1'b0; bus.a = '0; bus.b = '0;
    #12;
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_result", 32'(bus.result), 32'd0);
    check("rst_err", 32'(bus.err), 32'd0);
    check("rst_err_idx", 32'(bus.err_idx), 32'd0);
    check("rst_err_op", 32'(bus.err_op), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Directed table.
    foreach (tbl[i]) begin
      do_op(tbl[i].a, tbl[i].b, 1'b1, r, e, ei, eo, lat, busy_n);
      check($sformatf("tbl%0d_result", i), 32'(r), 32'(tbl[i].res));
      check($sformatf("tbl%0d_err", i), 32'(e), 32'(tbl[i].err));
      check($sformatf("tbl%0d_err_idx", i), 32'(ei), 32'(tbl[i].idx));
      check($sformatf("tbl%0d_err_op", i), 32'(eo), 32'(tbl[i].op));
      check($sformatf("tbl%0d_latency", i), 32'(lat), 32'(tbl[i].lat));
      check($sformatf("tbl%0d_busy_cycles", i), 32'(busy_n), 32'(tbl[i].lat + 1));
    end

    // Hold start high: one operation every 6 cycles; starts during RUN/DONE are dropped.
    @(negedge clk);
    bus.a = 16'h4321; bus.b = 16'h1111; bus.start = 1'b1;
    dones = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (bus.done) begin
        dones++;
        check("held_start_result", 32'(bus.result), 32'h05432);
      end
    end
    bus.start = 1'b0;
    check("held_start_done_count", 32'(dones), 32'd5);
    repeat (2) @(negedge clk);

    // Assert reset mid-operation: outputs clear at once and no done follows.
    @(negedge clk);
    bus.a = 16'h1234; bus.b = 16'h5678; bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst_busy", 32'(bus.busy), 32'd0);
    check("midrst_done", 32'(bus.done), 32'd0);
    check("midrst_result", 32'(bus.result), 32'd0);
    check("midrst_err", 32'(bus.err), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    dones = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.done) dones++;
    end
    check("midrst_no_done", 32'(dones), 32'd0);
    do_op(16'h0000, 16'h0000, 1'b0, r, e, ei, eo, lat, busy_n);
    check("postrst_result", 32'(r), 32'h00000);
    check("postrst_latency", 32'(lat), 32'd4);

    // Random operands with occasional non-BCD nibbles, checked against the model.
    for (int n = 0; n < 40; n++) begin
      for (int i = 0; i < D; i++) begin
        ra[4*i +: 4] = ($urandom_range(0, 11) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
        rb[4*i +: 4] = ($urandom_range(0, 11) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
      end
      model(ra, rb, mr, me, mei, meo, mlat);
      do_op(ra, rb, 1'b1, r, e, ei, eo, lat, busy_n);
      check($sformatf("rnd%0d_result a=%h b=%h", n, ra, rb), 32'(r), 32'(mr));
      check($sformatf("rnd%0d_err", n), 32'(e), 32'(me));
      check($sformatf("rnd%0d_err_idx", n), 32'(ei), 32'(mei));
      check($sformatf("rnd%0d_err_op", n), 32'(eo), 32'(meo));
      check($sformatf("rnd%0d_latency", n), 32'(lat), 32'(mlat));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end
endmodule
